imem_loader: RTL and testbench

Byte-stream program loader that fills the processor's 16-bit instruction memory before execution. It accepts a framed byte stream (count, payload, checksum) over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written to consecutive instruction-memory addresses starting at 0. While loading, the CPU is held in reset; it is released only after a good checksum. The block sits between the external load port and the computer's instmem write port / CPU reset input.

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the 16-bit instruction memory.
// Holds the CPU in reset until a frame with a good checksum has been written.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_COUNT,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHECK,
      S_RUN,
      S_ERR
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [8:0] count;
   logic [8:0] word_cnt;
   logic [8:0] word_cnt_inc;
   logic [7:0] hi_byte;
   logic [7:0] csum;
   logic       accept;
   logic       too_big;

   assign accept       = in_valid && in_ready;
   assign word_cnt_inc = word_cnt + 9'd1;
   assign too_big      = 32'(in_data) > DEPTH;

   always_comb begin
      in_ready = 1'b0;
      mem_we   = 1'b0;
      unique case (state)
         S_COUNT, S_HI, S_LO, S_CHECK: in_ready = 1'b1;
         S_WRITE:                      mem_we   = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_COUNT: begin
            if (accept) begin
               if (too_big)
                  state_nxt = S_ERR;
               else if (in_data == 8'd0)
                  state_nxt = S_CHECK;
               else
                  state_nxt = S_HI;
            end
         end
         S_HI: begin
            if (accept)
               state_nxt = S_LO;
         end
         S_LO: begin
            if (accept)
               state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (word_cnt_inc == count)
               state_nxt = S_CHECK;
            else
               state_nxt = S_HI;
         end
         S_CHECK: begin
            if (accept)
               state_nxt = (in_data == csum) ? S_RUN : S_ERR;
         end
         S_RUN:   state_nxt = S_RUN;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_COUNT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_COUNT;
         count     <= 9'd0;
         word_cnt  <= 9'd0;
         hi_byte   <= 8'd0;
         csum      <= 8'd0;
         mem_addr  <= '0;
         mem_wdata <= 16'd0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_COUNT && accept)
            count <= {1'b0, in_data};
         if (state == S_HI && accept) begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
         end
         if (state == S_LO && accept) begin
            csum      <= csum ^ in_data;
            mem_wdata <= {hi_byte, in_data};
         end
         if (state == S_WRITE) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            word_cnt <= word_cnt_inc;
         end
         // Status flags track the state being entered so they flip on that edge.
         cpu_reset <= (state_nxt != S_RUN);
         done      <= (state_nxt == S_RUN);
         error     <= (state_nxt == S_ERR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus against a frame-level model.
// Drives a full-depth (ADDR_W=8) and a small (ADDR_W=2) loader.
module tb_imem_loader;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        sel;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic        valid_a, valid_b;
   logic        rdy_a, we_a, cpur_a, done_a, err_a;
   logic [7:0]  addr_a;
   logic [15:0] wdata_a;
   logic        rdy_b, we_b, cpur_b, done_b, err_b;
   logic [1:0]  addr_b;
   logic [15:0] wdata_b;

   logic        s_ready, s_we, s_cpur, s_done, s_err;
   logic [7:0]  s_addr;
   logic [15:0] s_wdata;

   logic [7:0]  frame[$];
   logic [7:0]  got_addr[$];
   logic [15:0] got_data[$];
   int          got_cyc[$];
   logic [7:0]  exp_addr[$];
   logic [15:0] exp_data[$];
   int          exp_cyc[$];
   logic        exp_good;
   bit          gap;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign valid_a = in_valid & ~sel;
   assign valid_b = in_valid & sel;
   assign s_ready = sel ? rdy_b : rdy_a;
   assign s_we    = sel ? we_b : we_a;
   assign s_addr  = sel ? {6'd0, addr_b} : addr_a;
   assign s_wdata = sel ? wdata_b : wdata_a;
   assign s_cpur  = sel ? cpur_b : cpur_a;
   assign s_done  = sel ? done_b : done_a;
   assign s_err   = sel ? err_b : err_a;

   imem_loader #(.ADDR_W(8)) u_big (
      .CLK(CLK), .RESET(RESET), .in_valid(valid_a), .in_data(in_data),
      .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_wdata(wdata_a), .cpu_reset(cpur_a), .done(done_a), .error(err_a)
   );

   imem_loader #(.ADDR_W(2)) u_small (
      .CLK(CLK), .RESET(RESET), .in_valid(valid_b), .in_data(in_data),
      .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .cpu_reset(cpur_b), .done(done_b), .error(err_b)
   );

   // Captures every instmem write of the selected loader.
   always @(negedge CLK) begin
      if (s_we === 1'b1) begin
         got_addr.push_back(s_addr);
         got_data.push_back(s_wdata);
         got_cyc.push_back(cyc);
         checks++;
         if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_write got=%b exp=0", s_ready);
         end
      end
   end

   function automatic void build_model(int depth);
      int n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = int'(frame[0]);
      exp_good = 1'b0;
      if (n > depth) return;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(8'(i % depth));
         exp_data.push_back({frame[1+2*i], frame[2+2*i]});
         x ^= frame[1+2*i] ^ frame[2+2*i];
      end
      exp_good = (frame[1+2*n] == x);
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
   endtask

   task automatic send_frame();
      int idx = 0;
      int budget = 0;
      int n;
      int c;
      bit acc;
      n = int'(frame[0]);
      exp_cyc.delete();
      while (idx < frame.size() && budget < 2000) begin
         @(negedge CLK);
         in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data = in_valid ? frame[idx] : 8'($urandom);
         c = cyc;
         acc = in_valid && s_ready;
         @(posedge CLK);
         if (acc) begin
            if (idx >= 2 && idx % 2 == 0 && idx <= 2 * n)
               exp_cyc.push_back(c + 1);
            idx++;
         end
         budget++;
      end
      @(negedge CLK);
      in_valid = 1'b0;
      checks++;
      if (idx != frame.size()) begin
         failures++;
         $display("FAIL handshake_timeout sent=%0d exp=%0d", idx, frame.size());
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RESET = 1'b1;
      in_valid = 1'b0;
      sel = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      checks += 7;
      if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
      if (s_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", s_we); end
      if (s_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", s_addr); end
      if (s_wdata !== 16'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0000", s_wdata); end
      if (s_cpur !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b exp=1", s_cpur); end
      if (s_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", s_done); end
      if (s_err !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", s_err); end
      RESET = 1'b0;
   endtask

   task automatic test_three_word();
      do_reset();
      sel = 1'b0;
      gap = 1'b0;
      frame = '{8'h03, 8'h98, 8'hC3, 8'h99, 8'h06, 8'h40, 8'h1C, 8'h98};
      build_model(256);
      send_frame();
      checks++;
      if (got_data.size() != exp_data.size()) begin
         failures++;
         $display("FAIL three_nwr got=%0d exp=%0d", got_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         checks += 3;
         if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL three_addr%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
         if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL three_data%0d got=%h exp=%h", i, got_data[i], exp_data[i]); end
         if (got_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL three_lat%0d got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]); end
      end
      checks += 4;
      if (s_done !== 1'b1) begin failures++; $display("FAIL three_done got=%b exp=1", s_done); end
      if (s_err !== 1'b0) begin failures++; $display("FAIL three_error got=%b exp=0", s_err); end
      if (s_cpur !== 1'b0) begin failures++; $display("FAIL three_cpu_reset got=%b exp=0", s_cpur); end
      if (s_ready !== 1'b0) begin failures++; $display("FAIL three_ready got=%b exp=0", s_ready); end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      sel = 1'b0;
      gap = 1'b0;
      frame = '{8'h03, 8'h98, 8'hC3, 8'h99, 8'h06, 8'h40, 8'h1C, 8'h99};
      build_model(256);
      send_frame();
      checks++;
      if (got_data.size() != exp_data.size()) begin
         failures++;
         $display("FAIL badcs_nwr got=%0d exp=%0d", got_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         checks += 2;
         if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL badcs_addr%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
         if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL badcs_data%0d got=%h exp=%h", i, got_data[i], exp_data[i]); end
      end
      checks += 4;
      if (s_done !== 1'b0) begin failures++; $display("FAIL badcs_done got=%b exp=0", s_done); end
      if (s_err !== 1'b1) begin failures++; $display("FAIL badcs_error got=%b exp=1", s_err); end
      if (s_cpur !== 1'b1) begin failures++; $display("FAIL badcs_cpu_reset got=%b exp=1", s_cpur); end
      if (s_ready !== 1'b0) begin failures++; $display("FAIL badcs_ready got=%b exp=0", s_ready); end
   endtask

   task automatic test_empty_and_overflow();
      do_reset();
      sel = 1'b0;
      gap = 1'b0;
      frame = '{8'h00, 8'h00};
      send_frame();
      checks += 3;
      if (got_data.size() != 0) begin failures++; $display("FAIL empty_nwr got=%0d exp=0", got_data.size()); end
      if (s_done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", s_done); end
      if (s_cpur !== 1'b0) begin failures++; $display("FAIL empty_cpu_reset got=%b exp=0", s_cpur); end
      do_reset();
      sel = 1'b1;
      frame = '{8'h05};
      send_frame();
      checks += 4;
      if (got_data.size() != 0) begin failures++; $display("FAIL ovf_nwr got=%0d exp=0", got_data.size()); end
      if (s_err !== 1'b1) begin failures++; $display("FAIL ovf_error got=%b exp=1", s_err); end
      if (s_done !== 1'b0) begin failures++; $display("FAIL ovf_done got=%b exp=0", s_done); end
      if (s_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", s_ready); end
   endtask

   task automatic test_small_boundary();
      logic [7:0] x;
      do_reset();
      sel = 1'b1;
      gap = 1'b1;
      frame = '{8'h04};
      x = 8'h00;
      for (int i = 0; i < 8; i++) begin
         frame.push_back(8'($urandom));
         x ^= frame[i+1];
      end
      frame.push_back(x);
      build_model(4);
      send_frame();
      checks++;
      if (got_data.size() != exp_data.size()) begin
         failures++;
         $display("FAIL full_nwr got=%0d exp=%0d", got_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         checks += 2;
         if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL full_addr%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
         if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL full_data%0d got=%h exp=%h", i, got_data[i], exp_data[i]); end
      end
      checks += 3;
      if (s_done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", s_done); end
      if (s_err !== 1'b0) begin failures++; $display("FAIL full_error got=%b exp=0", s_err); end
      if (s_addr !== 8'h00) begin failures++; $display("FAIL full_addr_wrap got=%h exp=00", s_addr); end
   endtask

   task automatic test_gapped();
      do_reset();
      sel = 1'b0;
      gap = 1'b1;
      frame = '{8'h03, 8'h98, 8'hC3, 8'h99, 8'h06, 8'h40, 8'h1C, 8'h98};
      build_model(256);
      send_frame();
      checks++;
      if (got_data.size() != exp_data.size()) begin
         failures++;
         $display("FAIL gap_nwr got=%0d exp=%0d", got_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         checks += 3;
         if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL gap_addr%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
         if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL gap_data%0d got=%h exp=%h", i, got_data[i], exp_data[i]); end
         if (got_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL gap_lat%0d got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]); end
      end
      checks += 2;
      if (s_done !== 1'b1) begin failures++; $display("FAIL gap_done got=%b exp=1", s_done); end
      if (s_cpur !== 1'b0) begin failures++; $display("FAIL gap_cpu_reset got=%b exp=0", s_cpur); end
   endtask

   task automatic test_reset_midload();
      do_reset();
      sel = 1'b0;
      gap = 1'b0;
      frame = '{8'h03, 8'h98, 8'hC3, 8'h99};
      send_frame();
      checks += 2;
      if (got_data.size() != 1) begin failures++; $display("FAIL mid_nwr got=%0d exp=1", got_data.size()); end
      else if (got_data[0] !== 16'h98C3) begin failures++; $display("FAIL mid_data got=%h exp=98c3", got_data[0]); end
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      checks += 6;
      if (s_addr !== 8'h00) begin failures++; $display("FAIL mid_rst_addr got=%h exp=00", s_addr); end
      if (s_wdata !== 16'h0) begin failures++; $display("FAIL mid_rst_wdata got=%h exp=0000", s_wdata); end
      if (s_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%b exp=0", s_we); end
      if (s_cpur !== 1'b1) begin failures++; $display("FAIL mid_rst_cpu_reset got=%b exp=1", s_cpur); end
      if (s_done !== 1'b0 || s_err !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b%b exp=00", s_done, s_err); end
      if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", s_ready); end
      RESET = 1'b0;
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      frame = '{8'h01, 8'h84, 8'h42, 8'hC6};
      build_model(256);
      send_frame();
      checks += 3;
      if (got_data.size() != 1) begin failures++; $display("FAIL fresh_nwr got=%0d exp=1", got_data.size()); end
      else if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
         failures++;
         $display("FAIL fresh_write got=%h:%h exp=%h:%h", got_addr[0], got_data[0], exp_addr[0], exp_data[0]);
      end
      if (s_done !== 1'b1) begin failures++; $display("FAIL fresh_done got=%b exp=1", s_done); end
      if (s_cpur !== 1'b0) begin failures++; $display("FAIL fresh_cpu_reset got=%b exp=0", s_cpur); end
   endtask

   task automatic test_random();
      int n;
      int depth;
      logic [7:0] x;
      for (int t = 0; t < 12; t++) begin
         do_reset();
         sel = 1'($urandom_range(0, 1));
         gap = 1'($urandom_range(0, 1));
         depth = sel ? 4 : 256;
         n = $urandom_range(0, 7);
         frame = '{8'(n)};
         if (n <= depth) begin
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
               frame.push_back(8'($urandom));
               x ^= frame[i+1];
            end
            if ($urandom_range(0, 3) == 0)
               x ^= 8'($urandom_range(1, 255));
            frame.push_back(x);
         end
         build_model(depth);
         send_frame();
         checks++;
         if (got_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL rnd%0d_nwr got=%0d exp=%0d", t, got_data.size(), exp_data.size());
         end
         foreach (exp_data[i]) if (i < got_data.size()) begin
            checks += 3;
            if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL rnd%0d_addr%0d got=%h exp=%h", t, i, got_addr[i], exp_addr[i]); end
            if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL rnd%0d_data%0d got=%h exp=%h", t, i, got_data[i], exp_data[i]); end
            if (got_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL rnd%0d_lat%0d got=%0d exp=%0d", t, i, got_cyc[i], exp_cyc[i]); end
         end
         checks += 3;
         if (s_done !== exp_good) begin failures++; $display("FAIL rnd%0d_done got=%b exp=%b", t, s_done, exp_good); end
         if (s_err !== !exp_good) begin failures++; $display("FAIL rnd%0d_error got=%b exp=%b", t, s_err, !exp_good); end
         if (s_cpur !== !exp_good) begin failures++; $display("FAIL rnd%0d_cpu_reset got=%b exp=%b", t, s_cpur, !exp_good); end
      end
   endtask

   initial begin
      RESET = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      sel = 1'b0;
      gap = 1'b0;
      test_reset();
      test_three_word();
      test_bad_checksum();
      test_empty_and_overflow();
      test_small_boundary();
      test_gapped();
      test_reset_midload();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
